qoa_slice_sequencer: RTL and testbench
======================================

Name: qoa_slice_sequencer

Overview:
Drives the byte-command port of the QOA decoder core. It accepts one packed 64-bit QOA slice, plus optional LMS history/weight seed values, and issues the matching command bytes. It then reads back each decoded 16-bit sample and hands it downstream on a valid/ready port. It sits between the SPI/host front end and the decoder core, replacing host-side byte sequencing.

Parameters:
PROC_CYCLES, 64, cycles to wait after a sample-decode strobe before the next strobe (covers 4 multiplies plus update); must be >= 1.
STROBE_GAP, 2, minimum strobe-low cycles between any two strobes; must be >= 1.

Ports:
sys_clk  input  1  clock
sys_rst  input  1  synchronous reset, active-high
slice_data  input  64  [63:60] scale-factor index sf; residual i (i=0..19) at [59-3i -: 3]
lms_init  input  1  when set at slice accept, seed history/weights before decoding
lms_vec  input  128  {h0,h1,h2,h3,w0,w1,w2,w3}, 16 bits each, h0 at [127:112]
slice_valid  input  1  slice offered
slice_ready  output  1  slice accepted when slice_valid & slice_ready
dec_byte  output  8  command/data byte to decoder (spi_in)
dec_strobe  output  1  one-cycle byte strobe to decoder (data_rdy)
rsp_byte  input  8  decoder response byte (spi_out)
samp_data  output  16  decoded sample, signed
samp_valid  output  1  sample available
samp_ready  input  1  downstream accepts sample
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset, sync active-high: all outputs 0, state IDLE, counters 0. slice_ready rises in the first cycle after sys_rst deasserts. Reset mid-slice aborts the slice immediately and discards any pending sample.
- All outputs are registered. dec_strobe is high exactly one cycle per byte, and dec_byte is stable during that cycle.
- Gap rule: after every strobe, at least STROBE_GAP low cycles pass before the next strobe. After a sample-decode strobe, PROC_CYCLES low cycles pass instead.
- IDLE: slice_ready=1. On accept, latch slice_data, lms_init and lms_vec, then drop slice_ready. Go to LMS_CMD if lms_init is set, otherwise SMP_CMD with residual counter r=0.
- LMS_CMD/LMS_HI/LMS_LO: run for k=0..7. Entries k<4 are history[k] (sel=0); entries k>=4 are weights[k-4] (sel=1).
  - LMS_CMD strobes command {4'b0, idx[1:0], sel, 1'b0}.
  - LMS_HI strobes value[15:8].
  - LMS_LO strobes value[7:0].
  - After k=7, go to SMP_CMD.
- SMP_CMD: strobe {sf, q_r, 1'b1}, then go to SMP_WAIT.
- SMP_WAIT: count PROC_CYCLES, then go to TX_HI.
- TX_HI: strobe 0x80. Capture rsp_byte into sample[15:8] exactly 1 cycle after the strobe cycle.
- TX_LO: strobe 0x00. Capture rsp_byte into sample[7:0] 1 cycle after the strobe.
- TX_END: strobe 0x00, which returns the decoder to its wait state. Then go to OUT.
- OUT: samp_valid=1 with samp_data held until samp_ready. samp_valid drops the cycle after the handshake. If r==19, return to IDLE; otherwise r++ and go to SMP_CMD.
- Backpressure: no new decoder strobe is issued while samp_valid is high. samp_ready high during idle has no effect.
- Each residual uses exactly 4 strobes; a slice uses 80 strobes, plus 24 when lms_init is set.
- slice_valid asserted while busy is ignored, with no latch.
- Residuals are emitted strictly in order 0..19. sf is constant for the slice.

Test Plan:
- Reset: hold sys_rst 3 cycles mid-slice -> all outputs 0, then slice_ready=1 one cycle after release, with no strobes pending.
- Slice with sf=3 and all residuals 0, lms_init=0 -> first strobe byte is 0x31, then 0x80, 0x00, 0x00, repeated 20×. Exactly 80 strobes; gap after each 0x31 is >= PROC_CYCLES.
- sf=2 with residual0=5, lms_init=0 -> first strobe 0x2B. With the decoder model returning 0x12 then 0x34, samp_data=0x1234.
- lms_init=1, lms_vec with h0=0xABCD and w3=0x2000 -> first strobes are 0x00, 0xAB, 0xCD; strobes 22–24 are 0x0E, 0x20, 0x00; then the first sample command.
- Hold samp_ready=0 for 50 cycles after the first samp_valid -> samp_data is stable and dec_strobe stays low throughout. Release -> next 0xS?1 command follows.
- Offer a second slice while busy -> it is not accepted until the 20th sample handshake. Also check strobe spacing >= STROBE_GAP throughout.

Source files
------------

// File: rtl/qoa_slice_sequencer.sv
// Feeds one packed QOA slice (plus optional LMS seed) to the decoder byte port and returns 20 decoded samples.
// Latency: first strobe 1 cycle after accept; each sample needs 4 strobes plus PROC_CYCLES of decoder work.
// Backpressure: slice_ready only in IDLE; no decoder strobe is issued while samp_valid waits on samp_ready.
module qoa_slice_sequencer #(
    parameter int PROC_CYCLES = 64,
    parameter int STROBE_GAP  = 2
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic [63:0]  slice_data,
    input  logic         lms_init,
    input  logic [127:0] lms_vec,
    input  logic         slice_valid,
    output logic         slice_ready,
    output logic [7:0]   dec_byte,
    output logic         dec_strobe,
    input  logic [7:0]   rsp_byte,
    output logic [15:0]  samp_data,
    output logic         samp_valid,
    input  logic         samp_ready,
    output logic         busy
);
    localparam int GMAX = (PROC_CYCLES > STROBE_GAP) ? PROC_CYCLES : STROBE_GAP;
    localparam int GW   = $clog2(GMAX + 1);

    typedef enum logic [3:0] {
        IDLE, LMS_CMD, LMS_HI, LMS_LO, SMP_CMD, SMP_WAIT, TX_HI, TX_LO, TX_END, OUT
    } state_t;

    state_t         state;
    logic [GW-1:0]  gap_cnt;
    logic [3:0]     sf_q;
    logic [59:0]    res_sr;
    logic [127:0]   lms_sr;
    logic [2:0]     k;
    logic [4:0]     r;
    logic [15:0]    sample_q;
    logic           hi_pend, lo_pend, cap_hi, cap_lo;
    logic           can_strobe;

    // gap_cnt reaching zero is the only gate on issuing the next strobe
    assign can_strobe = (gap_cnt == '0);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            sf_q        <= '0;
            res_sr      <= '0;
            lms_sr      <= '0;
            k           <= '0;
            r           <= '0;
            sample_q    <= '0;
            hi_pend     <= 1'b0;
            lo_pend     <= 1'b0;
            cap_hi      <= 1'b0;
            cap_lo      <= 1'b0;
            slice_ready <= 1'b0;
            dec_byte    <= '0;
            dec_strobe  <= 1'b0;
            samp_data   <= '0;
            samp_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            dec_strobe <= 1'b0;
            if (gap_cnt != '0)
                gap_cnt <= gap_cnt - GW'(1);

            // response byte is valid in the cycle after its strobe
            hi_pend <= 1'b0;
            lo_pend <= 1'b0;
            cap_hi  <= hi_pend;
            cap_lo  <= lo_pend;
            if (cap_hi)
                sample_q[15:8] <= rsp_byte;
            if (cap_lo)
                sample_q[7:0] <= rsp_byte;

            case (state)
                IDLE: begin
                    if (slice_ready && slice_valid) begin
                        slice_ready <= 1'b0;
                        busy        <= 1'b1;
                        sf_q        <= slice_data[63:60];
                        res_sr      <= slice_data[59:0];
                        lms_sr      <= lms_vec;
                        k           <= '0;
                        r           <= '0;
                        state       <= lms_init ? LMS_CMD : SMP_CMD;
                    end else begin
                        slice_ready <= 1'b1;
                    end
                end
                LMS_CMD: if (can_strobe) begin
                    dec_strobe <= 1'b1;
                    dec_byte   <= {4'b0000, k[1:0], k[2], 1'b0};
                    gap_cnt    <= GW'(STROBE_GAP);
                    state      <= LMS_HI;
                end
                LMS_HI: if (can_strobe) begin
                    dec_strobe <= 1'b1;
                    dec_byte   <= lms_sr[127:120];
                    gap_cnt    <= GW'(STROBE_GAP);
                    state      <= LMS_LO;
                end
                LMS_LO: if (can_strobe) begin
                    dec_strobe <= 1'b1;
                    dec_byte   <= lms_sr[119:112];
                    gap_cnt    <= GW'(STROBE_GAP);
                    lms_sr     <= {lms_sr[111:0], 16'h0000};
                    k          <= k + 3'd1;
                    state      <= (k == 3'd7) ? SMP_CMD : LMS_CMD;
                end
                SMP_CMD: if (can_strobe) begin
                    dec_strobe <= 1'b1;
                    dec_byte   <= {sf_q, res_sr[59:57], 1'b1};
                    gap_cnt    <= GW'(PROC_CYCLES);
                    res_sr     <= {res_sr[56:0], 3'b000};
                    state      <= SMP_WAIT;
                end
                SMP_WAIT: if (can_strobe)
                    state <= TX_HI;
                TX_HI: if (can_strobe) begin
                    dec_strobe <= 1'b1;
                    dec_byte   <= 8'h80;
                    gap_cnt    <= GW'(STROBE_GAP);
                    hi_pend    <= 1'b1;
                    state      <= TX_LO;
                end
                TX_LO: if (can_strobe) begin
                    dec_strobe <= 1'b1;
                    dec_byte   <= 8'h00;
                    gap_cnt    <= GW'(STROBE_GAP);
                    lo_pend    <= 1'b1;
                    state      <= TX_END;
                end
                TX_END: if (can_strobe) begin
                    dec_strobe <= 1'b1;
                    dec_byte   <= 8'h00;
                    gap_cnt    <= GW'(STROBE_GAP);
                    state      <= OUT;
                end
                OUT: begin
                    if (!samp_valid) begin
                        samp_valid <= 1'b1;
                        samp_data  <= sample_q;
                    end else if (samp_ready) begin
                        samp_valid <= 1'b0;
                        if (r == 5'd19) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            r     <= r + 5'd1;
                            state <= SMP_CMD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qoa_slice_sequencer.sv
// Directed bench for qoa_slice_sequencer with a byte-level decoder model and a strobe/sample monitor.
module tb_qoa_slice_sequencer;
    localparam int PROC = 64;
    localparam int GAP  = 2;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic [63:0]  slice_data = '0;
    logic         lms_init = 1'b0;
    logic [127:0] lms_vec = '0;
    logic         slice_valid = 1'b0;
    logic         slice_ready;
    logic [7:0]   dec_byte;
    logic         dec_strobe;
    logic [7:0]   rsp_byte = 8'h00;
    logic [15:0]  samp_data;
    logic         samp_valid;
    logic         samp_ready = 1'b1;
    logic         busy;

    qoa_slice_sequencer #(.PROC_CYCLES(PROC), .STROBE_GAP(GAP)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .slice_data(slice_data), .lms_init(lms_init),
        .lms_vec(lms_vec), .slice_valid(slice_valid), .slice_ready(slice_ready),
        .dec_byte(dec_byte), .dec_strobe(dec_strobe), .rsp_byte(rsp_byte),
        .samp_data(samp_data), .samp_valid(samp_valid), .samp_ready(samp_ready), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input int n);
        logic [7:0] h, l;
        h = 8'h12 ^ 8'(n);
        l = 8'h34 + 8'(n);
        return {h, l};
    endfunction

    // Decoder model: registered response byte, valid only in the cycle after the strobe
    int dstate = 0;
    int dec_n  = 0;
    always @(posedge sys_clk) begin
        logic [15:0] mv;
        mv = model(dec_n);
        rsp_byte <= 8'hEE;
        if (sys_rst) begin
            dstate = 0;
            dec_n  = 0;
        end else if (dec_strobe) begin
            case (dstate)
                0: dstate = dec_byte[0] ? 3 : 1;
                1: dstate = 2;
                2: dstate = 0;
                3: begin rsp_byte <= mv[15:8]; dstate = 4; end
                4: begin rsp_byte <= mv[7:0];  dstate = 5; end
                default: begin dec_n++; dstate = 0; end
            endcase
        end
    end

    int           cyc = 0, last_strb = -1000, sidx = 0, sink_n = 0, slice_samp = 0, acc_prev_samp = 0;
    logic         last_was_cmd = 1'b0;
    logic         cur_lms = 1'b0;
    logic [63:0]  cur_slice = '0;
    logic [127:0] cur_vec = '0;
    logic [7:0]   slog [0:127];
    logic [15:0]  first_samp = '0;

    function automatic logic is_cmd(input int i);
        int off;
        off = cur_lms ? 24 : 0;
        if (cur_lms && i < 24) return 1'b0;
        return ((i - off) % 4) == 0;
    endfunction

    function automatic logic [7:0] exp_byte(input int i);
        int kk, j, rr;
        logic [2:0]  ki, q;
        logic [15:0] v;
        if (cur_lms && i < 24) begin
            kk = i / 3;
            ki = 3'(kk);
            v  = 16'(cur_vec >> (112 - 16 * kk));
            case (i % 3)
                0:       return {4'b0000, ki[1:0], ki[2], 1'b0};
                1:       return v[15:8];
                default: return v[7:0];
            endcase
        end
        j  = cur_lms ? i - 24 : i;
        rr = j / 4;
        q  = 3'(cur_slice >> (57 - 3 * rr));
        case (j % 4)
            0:       return {cur_slice[63:60], q, 1'b1};
            1:       return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    // Monitor samples DUT outputs at the falling edge
    always @(negedge sys_clk) begin
        int need;
        cyc++;
        if (sys_rst) begin
            last_was_cmd = 1'b0;
            sink_n = 0;
            sidx = 0;
        end else begin
            if (dec_strobe) begin
                need = last_was_cmd ? PROC : GAP;
                checks++;
                if (cyc - last_strb - 1 < need) begin
                    errors++;
                    $display("FAIL strobe_gap: got %0d low cycles before strobe %0d, required >= %0d",
                             cyc - last_strb - 1, sidx, need);
                end
                chk("strobe_byte", 32'(dec_byte), 32'(exp_byte(sidx)));
                if (sidx < 128) slog[sidx] = dec_byte;
                last_was_cmd = is_cmd(sidx);
                last_strb = cyc;
                sidx++;
            end
            if (samp_valid && samp_ready) begin
                chk("samp_data", 32'(samp_data), 32'(model(sink_n)));
                if (slice_samp == 0) first_samp = samp_data;
                sink_n++;
                slice_samp++;
            end
            if (slice_valid && slice_ready) begin
                acc_prev_samp = slice_samp;
                slice_samp = 0;
                sidx = 0;
                cur_lms = lms_init;
                cur_slice = slice_data;
                cur_vec = lms_vec;
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic l, input logic [127:0] v);
        int n = 0;
        @(posedge sys_clk); #1;
        slice_data = d; lms_init = l; lms_vec = v; slice_valid = 1'b1;
        do begin @(negedge sys_clk); n++; end while (!slice_ready && n < 6000);
        chk("accept_timeout", 32'(slice_ready), 32'd1);
        @(posedge sys_clk); #1;
        slice_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!(slice_samp == 20 && !busy) && n < 6000) begin @(negedge sys_clk); n++; end
        checks++;
        if (n >= 6000) begin
            errors++;
            $display("FAIL %s: timeout with %0d samples, required 20", nm, slice_samp);
        end
    endtask

    task automatic wait_sidx(input int target);
        int n = 0;
        while (sidx < target && n < 3000) begin @(negedge sys_clk); n++; end
        chk("strobe_wait_timeout", 32'(sidx >= target), 32'd1);
    endtask

    // Holds reset for three clock edges and checks the release behaviour
    task automatic do_reset(input string nm);
        int bad = 0;
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            if (i > 0 && (slice_ready || dec_strobe || samp_valid || busy || dec_byte != 8'h00 || samp_data != 16'h0000))
                bad++;
        end
        chk({nm, "_outputs_zero"}, 32'(bad), 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk({nm, "_ready_before"}, 32'(slice_ready), 32'd0);
        @(negedge sys_clk);
        chk({nm, "_ready_after"}, 32'(slice_ready), 32'd1);
        bad = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (dec_strobe || busy || samp_valid) bad++;
        end
        chk({nm, "_quiet"}, 32'(bad), 32'd0);
    endtask

    typedef struct {
        logic [63:0]  slice;
        logic         lms;
        logic [127:0] vec;
        logic [7:0]   exp_first;
        int           exp_strobes;
        logic [15:0]  exp_samp0;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int bad;
        int n;
        logic [15:0] hold;

        tbl[0] = '{64'h2A00_0000_0000_0000, 1'b0, 128'h0, 8'h2B, 80, 16'h1234};
        tbl[1] = '{64'h3000_0000_0000_0000, 1'b0, 128'h0, 8'h31, 80, 16'h0648};
        tbl[2] = '{64'h1FAC_6889_2468_ACE1, 1'b1,
                   128'hABCD_1111_2222_3333_4444_5555_6666_2000, 8'h00, 104, 16'h3A5C};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 128'h0, 8'hFF, 80, 16'h2E70};

        do_reset("init_reset");

        // Reset mid-slice aborts it
        send(64'h3000_0000_0000_0000, 1'b0, 128'h0);
        wait_sidx(6);
        do_reset("mid_reset");

        for (int t = 0; t < 4; t++) begin
            send(tbl[t].slice, tbl[t].lms, tbl[t].vec);
            wait_done("slice_done");
            chk("first_strobe", 32'(slog[0]), 32'(tbl[t].exp_first));
            chk("strobe_count", 32'(sidx), 32'(tbl[t].exp_strobes));
            chk("sample_count", 32'(slice_samp), 32'd20);
            chk("first_sample", 32'(first_samp), 32'(tbl[t].exp_samp0));
            if (tbl[t].lms) begin
                chk("lms_h0_hi", 32'(slog[1]), 32'h0000_00AB);
                chk("lms_h0_lo", 32'(slog[2]), 32'h0000_00CD);
                chk("lms_w3_cmd", 32'(slog[21]), 32'h0000_000E);
                chk("lms_w3_hi", 32'(slog[22]), 32'h0000_0020);
                chk("lms_w3_lo", 32'(slog[23]), 32'h0000_0000);
                chk("lms_first_smp", 32'(slog[24]), 32'h0000_001F);
            end
        end

        // Backpressure: hold samp_ready low for 50 cycles after the first sample
        @(posedge sys_clk); #1;
        samp_ready = 1'b0;
        send(64'h2A00_0000_0000_0000, 1'b0, 128'h0);
        n = 0;
        while (!samp_valid && n < 3000) begin @(negedge sys_clk); n++; end
        chk("bp_valid_seen", 32'(samp_valid), 32'd1);
        hold = samp_data;
        bad = 0;
        repeat (50) begin
            @(negedge sys_clk);
            if (samp_data !== hold || dec_strobe || !samp_valid) bad++;
        end
        chk("bp_hold", 32'(bad), 32'd0);
        chk("bp_strobes_held", 32'(sidx), 32'd4);

        // Release and offer a second slice while still busy; the data changes before acceptance
        @(posedge sys_clk); #1;
        samp_ready = 1'b1;
        slice_data = 64'hFFFF_FFFF_FFFF_FFFF;
        lms_init = 1'b0;
        lms_vec = '0;
        slice_valid = 1'b1;
        wait_sidx(5);
        chk("bp_next_cmd", 32'(slog[4]), 32'h0000_0021);
        repeat (100) @(negedge sys_clk);
        @(posedge sys_clk); #1;
        slice_data = 64'h3000_0000_0000_0000;
        n = 0;
        do begin @(negedge sys_clk); n++; end while (!slice_ready && n < 6000);
        chk("busy_accept_seen", 32'(slice_ready), 32'd1);
        @(posedge sys_clk); #1;
        slice_valid = 1'b0;
        chk("busy_accept_after_20", 32'(acc_prev_samp), 32'd20);
        wait_done("second_slice");
        chk("second_first_strobe", 32'(slog[0]), 32'h0000_0031);
        chk("second_strobe_count", 32'(sidx), 32'd80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
